// File: rtl/spi_flash_stream_if.sv
// rtl/spi_flash_stream_if.sv - SPI lane plus backing-store read port of the flash model
interface spi_flash_stream_if #(
  parameter int CS_NUM = 2
);
  logic [CS_NUM-1:0] cs_n;
  logic              mosi;
  logic              miso;
  logic              err;
  logic              rd_en;
  logic [63:0]       rd_addr;
  logic [63:0]       rd_data;

  modport master (
    output cs_n, mosi, rd_data,
    input  miso, err, rd_en, rd_addr
  );

  modport slave (
    input  cs_n, mosi, rd_data,
    output miso, err, rd_en, rd_addr
  );
endinterface

// File: rtl/spi_flash_stream.sv
// rtl/spi_flash_stream.sv - single-lane SPI NOR flash model: 03h/0Bh streaming read, 9Fh ID, 05h status
module spi_flash_stream #(
  parameter int          CS_NUM   = 2,
  parameter int          CS_SEL   = 0,
  parameter int          ADDR_W   = 24,
  parameter int          DUMMY    = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input logic                clk,
  input logic                reset,
  spi_flash_stream_if.slave  bus
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STAT, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         buf_q, buf_d;
  logic [63:0]         nxt_q, nxt_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                sel;
  logic                fetch;
  logic                unused_cs;

  assign sel       = ~bus.cs_n[CS_SEL];
  assign unused_cs = ^bus.cs_n;
  assign bus.rd_en = fetch;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      nxt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    nxt_d   = nxt_q;
    pend_d  = fetch;
    err_d   = err_q;
    if (!sel) begin
      state_d = S_CMD;
      cnt_d   = '0;
      cmd_d   = '0;
      pend_d  = 1'b0;
    end else begin
      // Data requested last cycle: the address-phase fetch fills the live buffer, prefetches the next one
      if (pend_q) begin
        if (state_q == S_ADDR) buf_d = bus.rd_data;
        else                   nxt_d = bus.rd_data;
      end
      unique case (state_q)
        S_CMD: begin
          cmd_d = {cmd_q[6:0], bus.mosi};
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd7) begin
            cnt_d = '0;
            unique case (cmd_d)
              8'h03, 8'h0B: state_d = S_ADDR;
              8'h9F:        state_d = S_ID;
              8'h05:        state_d = S_STAT;
              default: begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end
            endcase
          end
        end
        S_ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], bus.mosi};
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == 16'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = (cmd_q == 8'h0B && DUMMY > 0) ? S_DUMMY : S_DATA;
          end
        end
        S_DUMMY: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'(DUMMY - 1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q[2:0] == 3'd7) buf_d = nxt_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_ID: begin
          if (cnt_q < 16'd24) cnt_d = cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fetch       = 1'b0;
    bus.rd_addr = '0;
    bus.miso    = 1'b0;
    if (sel) begin
      if (state_q == S_ADDR && cnt_q == 16'(ADDR_W - 3)) begin
        fetch                     = 1'b1;
        bus.rd_addr[ADDR_W-1:0]   = {addr_q[ADDR_W-4:0], 3'b000};
      end else if (state_q == S_DATA && addr_q[2:0] == 3'd7 && cnt_q[2:0] == 3'd0) begin
        fetch                     = 1'b1;
        bus.rd_addr[ADDR_W-1:0]   = {addr_q[ADDR_W-1:3] + (ADDR_W-3)'(1), 3'b000};
      end
    end
    unique case (state_q)
      S_DATA:  bus.miso = buf_q[{addr_q[2:0], ~cnt_q[2:0]}];
      S_ID:    if (cnt_q < 16'd24) bus.miso = JEDEC_ID[5'd23 - cnt_q[4:0]];
      default: bus.miso = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_stream.sv
// tb/tb_spi_flash_stream.sv - scoreboard bench for spi_flash_stream
module tb_spi_flash_stream;
  localparam int CS_NUM = 2;
  localparam int CS_SEL = 0;
  localparam int ADDR_W = 24;
  localparam int DUMMY  = 8;
  localparam logic [63:0] GARBAGE = 64'hDEADBEEF0BADF00D;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_stream_if #(.CS_NUM(CS_NUM)) bus ();

  spi_flash_stream #(
    .CS_NUM(CS_NUM), .CS_SEL(CS_SEL), .ADDR_W(ADDR_W), .DUMMY(DUMMY), .JEDEC_ID(24'hEF4018)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [63:0] addr;
  } rd_t;

  rd_t        exp_rd_q[$];
  logic [7:0] exp_byte_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         tcyc;
  int         nz_pre;
  logic       rd_pend;
  logic [63:0] rd_pend_addr;
  logic [63:0] mask = (64'd1 << ADDR_W) - 64'd1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:      return 64'h8877665544332211;
      64'h8:      return 64'h10FFEEDDCCBBAA99;
      64'h10:     return 64'hC7C6C5C4C3C2C1C0;
      64'hFFFFF8: return 64'hBBAA060504030201;
      default:    return {a[31:0] ^ 32'h5A5A5A5A, a[31:0]};
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [63:0] a);
    logic [63:0] w;
    w = mem_word({a[63:3], 3'b000});
    return w[{a[2:0], 3'b000} +: 8];
  endfunction

  task automatic cyc(input logic b, output logic mo);
    rd_t e;
    @(negedge clk);
    reset       = 1'b0;
    bus.rd_data = rd_pend ? mem_word(rd_pend_addr) : GARBAGE;
    rd_pend     = 1'b0;
    bus.cs_n    = '1;
    bus.cs_n[CS_SEL] = 1'b0;
    bus.mosi    = b;
    #1;
    mo = bus.miso;
    if (bus.rd_en === 1'b1) begin
      rd_pend      = 1'b1;
      rd_pend_addr = bus.rd_addr;
      if (exp_rd_q.size() == 0) begin
        check_eq("rd_unexpected", 64'(tcyc), 64'hFFFF);
      end else begin
        e = exp_rd_q.pop_front();
        check_eq("rd_cycle", 64'(tcyc), 64'(e.cyc));
        check_eq("rd_addr", bus.rd_addr, e.addr);
      end
    end
    tcyc++;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    logic mo;
    for (int i = n - 1; i >= 0; i--) begin
      cyc(v[i], mo);
      if (mo !== 1'b0) nz_pre++;
    end
  endtask

  task automatic recv_bytes(input int n);
    logic [7:0] got;
    logic [7:0] e;
    logic       mo;
    for (int j = 0; j < n; j++) begin
      got = '0;
      for (int b = 0; b < 8; b++) begin
        cyc(1'($urandom_range(1, 0)), mo);
        got = {got[6:0], mo};
      end
      if (exp_byte_q.size() == 0) begin
        check_eq("miso_extra", 64'(got), 64'hFFFF);
      end else begin
        e = exp_byte_q.pop_front();
        check_eq("miso_byte", 64'(got), 64'(e));
      end
    end
  endtask

  task automatic begin_txn();
    tcyc   = 0;
    nz_pre = 0;
    exp_rd_q.delete();
    exp_byte_q.delete();
  endtask

  task automatic deselect();
    @(negedge clk);
    reset       = 1'b0;
    bus.cs_n    = '1;
    bus.mosi    = 1'b0;
    bus.rd_data = GARBAGE;
    rd_pend     = 1'b0;
    #1;
    check_eq("desel_rd_en", 64'(bus.rd_en), 64'd0);
    @(negedge clk);
    #1;
    check_eq("desel_miso", 64'(bus.miso), 64'd0);
    check_eq("rd_missing", 64'(exp_rd_q.size()), 64'd0);
    exp_rd_q.delete();
  endtask

  task automatic reset_pulse(input logic keep_sel);
    @(negedge clk);
    reset       = 1'b1;
    bus.cs_n    = '1;
    if (keep_sel) bus.cs_n[CS_SEL] = 1'b0;
    bus.rd_data = GARBAGE;
    rd_pend     = 1'b0;
  endtask

  task automatic read_txn(input logic [7:0] op, input logic [63:0] start, input int n);
    logic [63:0] a;
    rd_t         r;
    int          base;
    base = 8 + ADDR_W + ((op == 8'h0B) ? DUMMY : 0);
    begin_txn();
    r.cyc  = 8 + ADDR_W - 3;
    r.addr = start & ~64'd7;
    exp_rd_q.push_back(r);
    for (int j = 0; j < n; j++) begin
      a = (start + 64'(j)) & mask;
      exp_byte_q.push_back(byte_at(a));
      if (a[2:0] == 3'd7) begin
        r.cyc  = base + 8 * j;
        r.addr = ((a + 64'd1) & mask) & ~64'd7;
        exp_rd_q.push_back(r);
      end
    end
    send_bits(64'(op), 8);
    send_bits(start, ADDR_W);
    if (op == 8'h0B) send_bits(64'($urandom), DUMMY);
    check_eq("pre_data_miso", 64'(nz_pre), 64'd0);
    recv_bytes(n);
    check_eq("bytes_left", 64'(exp_byte_q.size()), 64'd0);
    deselect();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.cs_n    = '1;
    bus.mosi    = 1'b0;
    bus.rd_data = '0;
    rd_pend     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_miso", 64'(bus.miso), 64'd0);
    check_eq("reset_err", 64'(bus.err), 64'd0);
    check_eq("reset_rd_en", 64'(bus.rd_en), 64'd0);
    check_eq("reset_rd_addr", bus.rd_addr, 64'd0);
    deselect();

    read_txn(8'h03, 64'h000000, 8);
    read_txn(8'h03, 64'h000005, 6);
    read_txn(8'h0B, 64'hFFFFFE, 3);

    begin_txn();
    exp_byte_q.push_back(8'hEF);
    exp_byte_q.push_back(8'h40);
    exp_byte_q.push_back(8'h18);
    exp_byte_q.push_back(8'h00);
    send_bits(64'h9F, 8);
    recv_bytes(4);
    deselect();

    begin_txn();
    exp_byte_q.push_back(8'h00);
    exp_byte_q.push_back(8'h00);
    send_bits(64'h05, 8);
    recv_bytes(2);
    deselect();

    begin_txn();
    exp_byte_q.push_back(8'h00);
    exp_byte_q.push_back(8'h00);
    send_bits(64'h02, 8);
    recv_bytes(2);
    check_eq("err_set", 64'(bus.err), 64'd1);
    deselect();
    check_eq("err_sticky", 64'(bus.err), 64'd1);
    reset_pulse(1'b0);
    deselect();
    check_eq("err_cleared", 64'(bus.err), 64'd0);

    begin_txn();
    send_bits(64'h03, 8);
    send_bits(64'hABC, 12);
    deselect();
    read_txn(8'h03, 64'h000010, 8);

    begin_txn();
    send_bits(64'h03, 8);
    send_bits(64'h5A5, 12);
    reset_pulse(1'b1);
    read_txn(8'h03, 64'h000010, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
